// File: rtl/spi_flash_reader_if.sv
// Request, data-delivery and byte-bus signals of spi_flash_reader, grouped so the
// reader (slave) and whoever drives it (master) see the same bundle.
interface spi_flash_reader_if;
   logic        i_Req;
   logic [23:0] i_Addr;
   logic [6:0]  i_Len;
   logic        o_Busy;
   logic        o_Err;
   logic [7:0]  o_Data;
   logic        o_Data_Valid;
   logic [6:0]  o_Data_Idx;
   logic        o_Done;
   logic [6:0]  o_TX_Count;
   logic [7:0]  o_TX_Byte;
   logic        o_TX_DV;
   logic        i_TX_Ready;
   logic [6:0]  i_RX_Count;
   logic        i_RX_DV;
   logic [7:0]  i_RX_Byte;

   modport slave (
      input  i_Req, i_Addr, i_Len, i_TX_Ready, i_RX_Count, i_RX_DV, i_RX_Byte,
      output o_Busy, o_Err, o_Data, o_Data_Valid, o_Data_Idx, o_Done,
             o_TX_Count, o_TX_Byte, o_TX_DV
   );

   modport master (
      output i_Req, i_Addr, i_Len, i_TX_Ready, i_RX_Count, i_RX_DV, i_RX_Byte,
      input  o_Busy, o_Err, o_Data, o_Data_Valid, o_Data_Idx, o_Done,
             o_TX_Count, o_TX_Byte, o_TX_DV
   );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: issues opcode, 24-bit address and dummy fill bytes over a
// byte-wide SPI master bus, and forwards the returned data bytes with their index.
module spi_flash_reader #(
   parameter logic [7:0] CMD_READ = 8'h03,
   parameter logic [6:0] MAX_LEN  = 7'd123
) (
   input logic               i_Clk,
   input logic               i_Rst_L,
   spi_flash_reader_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, FILL, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [23:0] addr;
   logic [6:0]  len;
   logic [6:0]  tx_cnt;
   logic [6:0]  tx_count;
   logic        armed;
   logic        tx_dv_p1;
   logic        busy;
   logic        err_p1;
   logic        data_vld_p1;
   logic        done_p1;
   logic [7:0]  data_p1;
   logic [6:0]  data_idx_p1;

   logic        len_ok;
   logic        req_ok;
   logic        req_bad;
   logic [6:0]  rx_idx;
   logic        rx_data;
   logic        rx_last;
   logic        issue;
   logic        tx_dv;
   logic [7:0]  tx_byte;

   assign len_ok  = (bus.i_Len != 7'd0) && (bus.i_Len <= MAX_LEN);
   assign req_ok  = (state == IDLE) && armed && bus.i_Req && len_ok;
   assign req_bad = (state == IDLE) && armed && bus.i_Req && !len_ok;
   assign rx_idx  = bus.i_RX_Count - 7'd4;
   // Header echo (bus indices 0..3) never reaches the data port.
   assign rx_data = (state != IDLE) && bus.i_RX_DV && (bus.i_RX_Count >= 7'd4);
   assign rx_last = rx_data && (rx_idx == len - 7'd1);
   // The previous-cycle strobe blocks back-to-back issue even if ready lingers high.
   assign issue   = bus.i_TX_Ready && !tx_dv_p1;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_dv     = 1'b0;
      tx_byte   = 8'h00;
      case (state)
         IDLE: begin
            if (req_ok) state_nxt = CMD;
         end
         CMD: begin
            tx_byte = CMD_READ;
            if (issue) begin
               tx_dv     = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            case (tx_cnt)
               7'd1:    tx_byte = addr[23:16];
               7'd2:    tx_byte = addr[15:8];
               default: tx_byte = addr[7:0];
            endcase
            if (issue) begin
               tx_dv = 1'b1;
               if (tx_cnt == 7'd3) state_nxt = FILL;
            end
         end
         FILL: begin
            if (tx_cnt == tx_count) state_nxt = DRAIN;
            else if (issue)         tx_dv     = 1'b1;
         end
         DRAIN: begin
         end
         default: state_nxt = IDLE;
      endcase
      // Completion can come from any active state; it always wins.
      if (rx_last) state_nxt = IDLE;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         armed       <= 1'b0;
         addr        <= 24'h0;
         len         <= 7'd0;
         tx_cnt      <= 7'd0;
         tx_count    <= 7'd0;
         tx_dv_p1    <= 1'b0;
         busy        <= 1'b0;
         err_p1      <= 1'b0;
         data_vld_p1 <= 1'b0;
         done_p1     <= 1'b0;
         data_p1     <= 8'h00;
         data_idx_p1 <= 7'd0;
      end else begin
         // Acceptance is held off until one edge after reset release.
         armed       <= 1'b1;
         tx_dv_p1    <= tx_dv;
         err_p1      <= req_bad;
         data_vld_p1 <= rx_data;
         done_p1     <= rx_last;
         if (rx_data) begin
            data_p1     <= bus.i_RX_Byte;
            data_idx_p1 <= rx_idx;
         end
         if (req_ok) begin
            addr     <= bus.i_Addr;
            len      <= bus.i_Len;
            tx_count <= bus.i_Len + 7'd4;
            tx_cnt   <= 7'd0;
            busy     <= 1'b1;
         end else if (tx_dv) begin
            tx_cnt <= tx_cnt + 7'd1;
         end
         if (rx_last) busy <= 1'b0;
      end
   end

   assign bus.o_Busy       = busy;
   assign bus.o_Err        = err_p1;
   assign bus.o_Data       = data_p1;
   assign bus.o_Data_Valid = data_vld_p1;
   assign bus.o_Data_Idx   = data_idx_p1;
   assign bus.o_Done       = done_p1;
   assign bus.o_TX_Count   = tx_count;
   assign bus.o_TX_Byte    = tx_byte;
   assign bus.o_TX_DV      = tx_dv;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: byte-bus model echoing MISO = (A0 + bus index) ^ salt,
// vector table plus hand-written corner sequences, scoreboard of expected TX/RX bytes.
module tb_spi_flash_reader;
   typedef struct {
      logic [23:0] addr;
      logic [6:0]  len;
      logic [7:0]  salt;
      int          gap;
      logic        err;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [6:0] idx;
      logic       last;
   } rx_exp_t;

   typedef struct {
      int         due;
      logic [6:0] idx;
      logic [7:0] dat;
   } pend_t;

   logic i_Clk   = 1'b0;
   logic i_Rst_L = 1'b0;
   always #5 i_Clk = ~i_Clk;

   spi_flash_reader_if bus ();
   spi_flash_reader dut (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .bus(bus));

   int         n_cmp    = 0;
   int         n_bad    = 0;
   int         err_cnt  = 0;
   int         done_cnt = 0;
   int         dv_cnt   = 0;
   int         cyc      = 0;
   int         gap      = 0;
   int         frame_len = 0;
   logic [7:0] salt     = 8'h00;
   bit         stray    = 1'b0;

   logic [7:0] exp_tx[$];
   rx_exp_t    exp_rx[$];
   pend_t      pend[$];
   vec_t       vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Bus model and output monitor, stepped once per negedge.
   initial begin
      int      hold;
      int      bus_idx;
      int      last_due;
      logic    prev_dv;
      rx_exp_t e;
      pend_t   p;
      hold = 0; bus_idx = 0; last_due = 0; prev_dv = 1'b0;
      bus.i_TX_Ready = 1'b1;
      bus.i_RX_DV    = 1'b0;
      bus.i_RX_Count = 7'd0;
      bus.i_RX_Byte  = 8'h00;
      forever begin
         @(negedge i_Clk);
         if (bus.o_Data_Valid) begin
            dv_cnt++;
            chk("rx_expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) begin
               e = exp_rx.pop_front();
               chk("data", bus.o_Data, e.data);
               chk("data_idx", bus.o_Data_Idx, e.idx);
               chk("done_flag", bus.o_Done, e.last);
            end
         end
         if (bus.o_Done) begin
            done_cnt++;
            chk("done_with_valid", bus.o_Data_Valid, 1);
            chk("busy_at_done", bus.o_Busy, 0);
         end
         if (bus.o_Err) err_cnt++;

         if (!i_Rst_L) begin
            pend.delete();
            bus_idx = 0; hold = 0; last_due = 0;
            bus.i_TX_Ready = 1'b1;
            bus.i_RX_DV    = 1'b0;
         end else begin
            if (stray) begin
               bus.i_RX_DV    = 1'b1;
               bus.i_RX_Count = 7'd6;
               bus.i_RX_Byte  = 8'h5A;
               stray = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
               p = pend.pop_front();
               bus.i_RX_DV    = 1'b1;
               bus.i_RX_Count = p.idx;
               bus.i_RX_Byte  = p.dat;
            end else begin
               bus.i_RX_DV = 1'b0;
            end
            if (hold > 0) begin
               bus.i_TX_Ready = 1'b0;
               hold--;
            end else begin
               bus.i_TX_Ready = 1'b1;
            end
         end

         #1;
         if (bus.o_TX_DV) begin
            chk("dv_with_ready", bus.i_TX_Ready, 1);
            chk("dv_not_consecutive", prev_dv, 0);
            chk("tx_count_stable", bus.o_TX_Count, frame_len);
            chk("tx_expected", exp_tx.size() > 0, 1);
            if (exp_tx.size() > 0) chk("tx_byte", bus.o_TX_Byte, exp_tx.pop_front());
            p.due    = (cyc + 2 + int'($urandom_range(0, 3)) > last_due) ?
                       cyc + 2 + int'($urandom_range(0, 3)) : last_due + 1;
            if (p.due <= last_due) p.due = last_due + 1;
            last_due = p.due;
            p.idx    = 7'(bus_idx);
            p.dat    = (8'hA0 + 8'(bus_idx)) ^ salt;
            pend.push_back(p);
            bus_idx++;
            if (bus_idx >= frame_len) bus_idx = 0;
            hold = gap;
         end
         prev_dv = bus.o_TX_DV;
         cyc++;
      end
   end

   task automatic do_reset();
      i_Rst_L   = 1'b0;
      bus.i_Req = 1'b0;
      #1;
      chk("rst_busy", bus.o_Busy, 0);
      chk("rst_err", bus.o_Err, 0);
      chk("rst_data", bus.o_Data, 0);
      chk("rst_data_valid", bus.o_Data_Valid, 0);
      chk("rst_data_idx", bus.o_Data_Idx, 0);
      chk("rst_done", bus.o_Done, 0);
      chk("rst_tx_count", bus.o_TX_Count, 0);
      chk("rst_tx_byte", bus.o_TX_Byte, 0);
      chk("rst_tx_dv", bus.o_TX_DV, 0);
      exp_tx.delete();
      exp_rx.delete();
      repeat (2) @(negedge i_Clk);
      i_Rst_L = 1'b1;
      @(negedge i_Clk);
   endtask

   // Called at a negedge (or just after); returns one negedge later.
   task automatic start_req(input logic [23:0] a, input logic [6:0] l,
                            input logic [7:0] s, input logic exp_err);
      rx_exp_t e;
      salt = s;
      if (!exp_err) begin
         frame_len = int'(l) + 4;
         exp_tx.push_back(8'h03);
         exp_tx.push_back(a[23:16]);
         exp_tx.push_back(a[15:8]);
         exp_tx.push_back(a[7:0]);
         for (int i = 0; i < int'(l); i++) exp_tx.push_back(8'h00);
         for (int i = 0; i < int'(l); i++) begin
            e.data = (8'hA0 + 8'(i + 4)) ^ s;
            e.idx  = 7'(i);
            e.last = (i == int'(l) - 1);
            exp_rx.push_back(e);
         end
      end
      bus.i_Req  = 1'b1;
      bus.i_Addr = a;
      bus.i_Len  = l;
      @(negedge i_Clk);
      bus.i_Req = 1'b0;
      if (exp_err) begin
         chk("err_pulse", bus.o_Err, 1);
         chk("err_not_busy", bus.o_Busy, 0);
         @(negedge i_Clk);
         chk("err_one_cycle", bus.o_Err, 0);
      end else begin
         chk("accept_busy", bus.o_Busy, 1);
         chk("accept_no_err", bus.o_Err, 0);
         chk("accept_tx_count", bus.o_TX_Count, int'(l) + 4);
      end
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge i_Clk);
         if (bus.o_Done) begin
            seen = 1'b1;
            break;
         end
      end
      #2;
      chk("done_seen", seen, 1);
      chk("tx_drained", exp_tx.size(), 0);
      chk("rx_drained", exp_rx.size(), 0);
      if (!seen) do_reset();
   endtask

   initial begin
      int   r;
      int   e0;
      int   d0;
      logic hit;
      bus.i_Req  = 1'b0;
      bus.i_Addr = 24'h0;
      bus.i_Len  = 7'd0;

      vecs[0] = '{addr: 24'h123456, len: 7'd2,   salt: 8'h00, gap: 0, err: 1'b0};
      vecs[1] = '{addr: 24'h000000, len: 7'd0,   salt: 8'h00, gap: 0, err: 1'b1};
      vecs[2] = '{addr: 24'hFFFFFF, len: 7'd124, salt: 8'h00, gap: 0, err: 1'b1};
      vecs[3] = '{addr: 24'h0A0B0C, len: 7'd123, salt: 8'h00, gap: 0, err: 1'b0};
      vecs[4] = '{addr: 24'h800001, len: 7'd1,   salt: 8'hFF, gap: 3, err: 1'b0};
      vecs[5] = '{addr: 24'h7FFFFF, len: 7'd127, salt: 8'h00, gap: 0, err: 1'b1};
      for (int i = 6; i < 16; i++) begin
         r = int'($urandom_range(0, 9));
         vecs[i].addr = 24'($urandom);
         if (r == 0) vecs[i].len = (($urandom & 1) != 0) ? 7'd0 : 7'(124 + $urandom_range(0, 3));
         else        vecs[i].len = 7'($urandom_range(1, 24));
         vecs[i].salt = 8'($urandom);
         vecs[i].gap  = int'($urandom_range(0, 3));
         vecs[i].err  = (vecs[i].len == 7'd0) || (vecs[i].len > 7'd123);
      end

      @(negedge i_Clk);
      do_reset();

      for (int i = 0; i < 16; i++) begin
         gap = vecs[i].gap;
         start_req(vecs[i].addr, vecs[i].len, vecs[i].salt, vecs[i].err);
         if (!vecs[i].err) wait_done();
      end

      // Long ready stalls between bytes.
      gap = 20;
      start_req(24'hC0FFEE, 7'd3, 8'h3C, 1'b0);
      wait_done();

      // Requests while busy, valid and invalid length, are ignored.
      gap = 2;
      e0 = err_cnt;
      start_req(24'hABCDEF, 7'd6, 8'h00, 1'b0);
      repeat (4) @(negedge i_Clk);
      bus.i_Req = 1'b1; bus.i_Addr = 24'h000000; bus.i_Len = 7'd5;
      @(negedge i_Clk);
      bus.i_Len = 7'd0;
      @(negedge i_Clk);
      bus.i_Req = 1'b0;
      chk("busy_req_tx_count", bus.o_TX_Count, 10);
      wait_done();
      chk("busy_req_no_err", err_cnt - e0, 0);

      // Back-to-back: next request presented in the cycle right after o_Done.
      gap = 0;
      start_req(24'h000100, 7'd4, 8'h11, 1'b0);
      wait_done();
      start_req(24'h000200, 7'd9, 8'h22, 1'b0);
      wait_done();

      // Receive strobe while idle produces nothing.
      d0 = dv_cnt;
      stray = 1'b1;
      repeat (4) @(negedge i_Clk);
      #2;
      chk("idle_rx_ignored", dv_cnt - d0, 0);

      // Reset after the second data byte abandons the read; a fresh one follows.
      gap = 1;
      d0 = done_cnt;
      start_req(24'h00F0F0, 7'd8, 8'h5A, 1'b0);
      hit = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge i_Clk);
         if (bus.o_Data_Valid && bus.o_Data_Idx == 7'd1) begin
            hit = 1'b1;
            break;
         end
      end
      #2;
      chk("second_byte_seen", hit, 1);
      do_reset();
      repeat (3) @(negedge i_Clk);
      chk("no_done_after_reset", done_cnt - d0, 0);
      start_req(24'h777777, 7'd1, 8'h01, 1'b0);
      wait_done();

      repeat (3) @(negedge i_Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end
endmodule
